// File: rtl/syscall_pkg.sv
// rtl/syscall_pkg.sv - syscall codes, FSM states and console type encodings
package syscall_pkg;

   localparam logic [31:0] SC_PRINT_INT = 32'd1;
   localparam logic [31:0] SC_PRINT_STR = 32'd4;
   localparam logic [31:0] SC_SBRK      = 32'd9;
   localparam logic [31:0] SC_EXIT      = 32'd10;
   localparam logic [31:0] SC_EXIT2     = 32'd17;

   localparam logic OUT_CHAR = 1'b0;
   localparam logic OUT_INT  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ALLOC,
      FETCH,
      WAIT,
      EMIT,
      INT,
      HALT
   } state_e;

endpackage

// File: rtl/syscall_engine_if.sv
// rtl/syscall_engine_if.sv - core, memory and console signals of the syscall engine
interface syscall_engine_if;
   logic        sc_valid;
   logic [31:0] sc_v0;
   logic [31:0] sc_a0;
   logic        sc_busy;
   logic        v0_we;
   logic [31:0] v0_wdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        out_valid;
   logic        out_type;
   logic [31:0] out_data;
   logic        out_ready;
   logic [31:0] heap_ptr;
   logic        halted;
   logic [7:0]  exit_code;
   logic        err;

   modport slave (
      input  sc_valid, sc_v0, sc_a0, mem_rdata, mem_ack, out_ready,
      output sc_busy, v0_we, v0_wdata, mem_req, mem_addr,
             out_valid, out_type, out_data, heap_ptr, halted, exit_code, err
   );

   modport master (
      output sc_valid, sc_v0, sc_a0, mem_rdata, mem_ack, out_ready,
      input  sc_busy, v0_we, v0_wdata, mem_req, mem_addr,
             out_valid, out_type, out_data, heap_ptr, halted, exit_code, err
   );
endinterface

// File: rtl/str_byte_sel.sv
// rtl/str_byte_sel.sv - big-endian byte pick from a word plus NUL detect
module str_byte_sel (
   input  logic [31:0] word,
   input  logic [1:0]  idx,
   output logic [7:0]  byte_val,
   output logic        is_nul
);

   always_comb begin
      case (idx)
         2'd0:    byte_val = word[31:24];
         2'd1:    byte_val = word[23:16];
         2'd2:    byte_val = word[15:8];
         default: byte_val = word[7:0];
      endcase
      is_nul = (byte_val == 8'd0);
   end

endmodule

// File: rtl/syscall_engine.sv
// rtl/syscall_engine.sv - print-int/print-string/sbrk/exit syscall engine
module syscall_engine
   import syscall_pkg::*;
#(
   parameter logic [31:0] HEAP_BASE = 32'h1000_0000,
   parameter logic [31:0] HEAP_SIZE = 32'h0000_00FC,
   parameter int unsigned ALIGN     = 4,
   parameter int unsigned MAX_STR   = 1024
) (
   input  logic             clk,
   input  logic             reset,
   syscall_engine_if.slave  bus
);

   localparam logic [32:0] ALIGN_M1 = 33'(ALIGN - 1);
   localparam logic [32:0] LIMIT    = {1'b0, HEAP_BASE} + {1'b0, HEAP_SIZE};
   localparam logic [31:0] MAX_CNT  = 32'(MAX_STR);

   state_e      state_q, state_d;
   logic [31:0] heap_ptr_q, heap_ptr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] count_q, count_d;
   logic [31:0] word_q, word_d;
   logic        v0_we_q, v0_we_d;
   logic [31:0] v0_wdata_q, v0_wdata_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        out_valid_q, out_valid_d;
   logic        out_type_q, out_type_d;
   logic [31:0] out_data_q, out_data_d;
   logic        halted_q, halted_d;
   logic [7:0]  exit_code_q, exit_code_d;
   logic        err_q, err_d;

   logic [32:0] size33, sum33;
   logic [31:0] addr_inc, cnt_inc;
   logic [7:0]  sel_byte;
   logic        sel_nul;

   str_byte_sel u_sel (
      .word     (word_q),
      .idx      (addr_q[1:0]),
      .byte_val (sel_byte),
      .is_nul   (sel_nul)
   );

   assign size33   = ({1'b0, bus.sc_a0} + ALIGN_M1) & ~ALIGN_M1;
   assign sum33    = {1'b0, heap_ptr_q} + size33;
   assign addr_inc = addr_q + 32'd1;
   assign cnt_inc  = count_q + 32'd1;

   always_comb begin
      state_d     = state_q;
      heap_ptr_d  = heap_ptr_q;
      addr_d      = addr_q;
      count_d     = count_q;
      word_d      = word_q;
      v0_we_d     = 1'b0;
      v0_wdata_d  = v0_wdata_q;
      mem_req_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      out_valid_d = out_valid_q;
      out_type_d  = out_type_q;
      out_data_d  = out_data_q;
      halted_d    = halted_q;
      exit_code_d = exit_code_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.sc_valid) begin
               case (bus.sc_v0)
                  SC_PRINT_INT: begin
                     state_d     = INT;
                     out_valid_d = 1'b1;
                     out_type_d  = OUT_INT;
                     out_data_d  = bus.sc_a0;
                  end
                  SC_PRINT_STR: begin
                     state_d    = FETCH;
                     addr_d     = bus.sc_a0;
                     count_d    = 32'd0;
                     mem_req_d  = 1'b1;
                     mem_addr_d = {bus.sc_a0[31:2], 2'b00};
                  end
                  SC_SBRK: begin
                     // Result is registered here so v0_we/heap_ptr/err all appear in ALLOC.
                     state_d = ALLOC;
                     v0_we_d = 1'b1;
                     if (sum33 <= LIMIT) begin
                        v0_wdata_d = heap_ptr_q;
                        heap_ptr_d = sum33[31:0];
                     end else begin
                        v0_wdata_d = 32'd0;
                        err_d      = 1'b1;
                     end
                  end
                  SC_EXIT: begin
                     state_d     = HALT;
                     halted_d    = 1'b1;
                     exit_code_d = 8'd0;
                  end
                  SC_EXIT2: begin
                     state_d     = HALT;
                     halted_d    = 1'b1;
                     exit_code_d = bus.sc_a0[7:0];
                  end
                  default: ;
               endcase
            end
         end
         ALLOC: state_d = IDLE;
         FETCH: state_d = WAIT;
         WAIT: begin
            if (bus.mem_ack) begin
               word_d  = bus.mem_rdata;
               state_d = EMIT;
            end
         end
         EMIT: begin
            // First cycle evaluates the byte; out_valid then holds it until accepted.
            if (!out_valid_q) begin
               if (sel_nul) begin
                  state_d = IDLE;
               end else begin
                  out_valid_d = 1'b1;
                  out_type_d  = OUT_CHAR;
                  out_data_d  = {24'd0, sel_byte};
               end
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               addr_d      = addr_inc;
               count_d     = cnt_inc;
               if (cnt_inc == MAX_CNT) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (addr_q[1:0] == 2'd3) begin
                  state_d    = FETCH;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {addr_inc[31:2], 2'b00};
               end
            end
         end
         INT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         HALT: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         heap_ptr_q  <= HEAP_BASE;
         addr_q      <= 32'd0;
         count_q     <= 32'd0;
         word_q      <= 32'd0;
         v0_we_q     <= 1'b0;
         v0_wdata_q  <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'd0;
         out_valid_q <= 1'b0;
         out_type_q  <= OUT_CHAR;
         out_data_q  <= 32'd0;
         halted_q    <= 1'b0;
         exit_code_q <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         heap_ptr_q  <= heap_ptr_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         word_q      <= word_d;
         v0_we_q     <= v0_we_d;
         v0_wdata_q  <= v0_wdata_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         out_type_q  <= out_type_d;
         out_data_q  <= out_data_d;
         halted_q    <= halted_d;
         exit_code_q <= exit_code_d;
         err_q       <= err_d;
      end
   end

   assign bus.sc_busy   = (state_q != IDLE) | bus.sc_valid;
   assign bus.v0_we     = v0_we_q;
   assign bus.v0_wdata  = v0_wdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_type  = out_type_q;
   assign bus.out_data  = out_data_q;
   assign bus.heap_ptr  = heap_ptr_q;
   assign bus.halted    = halted_q;
   assign bus.exit_code = exit_code_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_syscall_engine.sv
// tb/tb_syscall_engine.sv - scoreboard bench for syscall_engine
module tb_syscall_engine;

   localparam logic [31:0] BASE = 32'h1000_0000;

   typedef struct {
      logic        typ;
      logic [31:0] data;
   } out_exp_t;

   typedef struct {
      logic [31:0] wdata;
      logic [31:0] heap;
      logic        err;
   } v0_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_stall = 1'b0;
   logic [31:0] mem [0:3];
   int   check_cnt = 0;
   int   pass_cnt = 0;
   int   mem_req_cnt = 0;
   int   err_cnt = 0;
   out_exp_t out_q[$];
   v0_exp_t  v0_q[$];

   syscall_engine_if sif ();

   syscall_engine dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max_cycles);
      bit done = 0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         if (!sif.sc_busy) done = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) begin
         check_cnt++;
         $display("FAIL wait_idle: busy after %0d cycles, required idle", max_cycles);
      end
   endtask

   task automatic issue(input logic [31:0] code, input logic [31:0] a0);
      wait_idle(200);
      sif.sc_valid = 1'b1;
      sif.sc_v0    = code;
      sif.sc_a0    = a0;
      @(posedge clk);
      #1;
      sif.sc_valid = 1'b0;
   endtask

   // Memory responder: one-cycle ack latency, dropped when stalled.
   initial begin
      sif.mem_ack   = 1'b0;
      sif.mem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sif.mem_req) begin
            mem_req_cnt++;
            if (!mem_stall) begin
               @(posedge clk);
               #1;
               check("mem_req_outstanding", {31'd0, sif.mem_req}, 32'd0);
               sif.mem_ack   = 1'b1;
               sif.mem_rdata = mem[sif.mem_addr[3:2]];
               @(posedge clk);
               #1;
               sif.mem_ack = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && sif.out_valid && sif.out_ready) begin
         if (out_q.size() == 0) begin
            check_cnt++;
            $display("FAIL out_unexpected: got data %h, required no transfer", sif.out_data);
         end else begin
            out_exp_t e;
            e = out_q.pop_front();
            check("out_type", {31'd0, sif.out_type}, {31'd0, e.typ});
            check("out_data", sif.out_data, e.data);
         end
      end
      if (rst_n && sif.v0_we) begin
         if (v0_q.size() == 0) begin
            check_cnt++;
            $display("FAIL v0_unexpected: got v0_wdata %h, required no write", sif.v0_wdata);
         end else begin
            v0_exp_t v;
            v = v0_q.pop_front();
            check("v0_wdata", sif.v0_wdata, v.wdata);
            check("heap_ptr", sif.heap_ptr, v.heap);
            check("sbrk_err", {31'd0, sif.err}, {31'd0, v.err});
         end
      end
      if (rst_n && sif.err) err_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      sif.sc_valid  = 1'b0;
      sif.sc_v0     = 32'd0;
      sif.sc_a0     = 32'd0;
      sif.out_ready = 1'b1;
      mem[0] = 32'h4142_4344;
      mem[1] = 32'h4500_0000;
      mem[2] = 32'h0;
      mem[3] = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_heap_ptr", sif.heap_ptr, BASE);
      check("rst_halted", {31'd0, sif.halted}, 32'd0);
      check("rst_exit_code", {24'd0, sif.exit_code}, 32'd0);
      check("rst_out_valid", {31'd0, sif.out_valid}, 32'd0);
      check("rst_mem_req", {31'd0, sif.mem_req}, 32'd0);
      check("rst_v0_we", {31'd0, sif.v0_we}, 32'd0);
      check("rst_err", {31'd0, sif.err}, 32'd0);
      check("rst_busy", {31'd0, sif.sc_busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // sbrk rounding and advance
      v0_q.push_back('{BASE, BASE + 32'h8, 1'b0});
      issue(32'd9, 32'd5);
      v0_q.push_back('{BASE + 32'h8, BASE + 32'hC, 1'b0});
      issue(32'd9, 32'd4);
      wait_idle(20);

      // sbrk overflow from a fresh heap
      do_reset();
      e0 = err_cnt;
      v0_q.push_back('{32'd0, BASE, 1'b1});
      issue(32'd9, 32'h100);
      wait_idle(20);
      repeat (2) @(posedge clk);
      #1;
      check("sbrk_err_pulses", 32'(err_cnt - e0), 32'd1);

      // unknown code: no output, no state change
      issue(32'd3, 32'd7);
      #1;
      check("unknown_busy", {31'd0, sif.sc_busy}, 32'd0);
      check("unknown_heap", sif.heap_ptr, BASE);

      // print string starting mid-word
      mem_req_cnt = 0;
      out_q.push_back('{1'b0, 32'h43});
      out_q.push_back('{1'b0, 32'h44});
      out_q.push_back('{1'b0, 32'h45});
      issue(32'd4, 32'h0000_0002);
      repeat (2) @(posedge clk);
      wait_idle(100);
      check("str_mem_reqs", 32'(mem_req_cnt), 32'd2);
      check("str_out_left", 32'(out_q.size()), 32'd0);

      // print int with back-pressure
      sif.out_ready = 1'b0;
      out_q.push_back('{1'b1, 32'hFFFF_FFFF});
      issue(32'd1, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         check("int_hold_valid", {31'd0, sif.out_valid}, 32'd1);
         check("int_hold_data", sif.out_data, 32'hFFFF_FFFF);
         @(posedge clk);
         #1;
      end
      sif.out_ready = 1'b1;
      wait_idle(20);
      check("int_out_left", 32'(out_q.size()), 32'd0);

      // exit with code, then ignored request
      issue(32'd17, 32'h1AB);
      check("halt_halted", {31'd0, sif.halted}, 32'd1);
      check("halt_exit_code", {24'd0, sif.exit_code}, 32'hAB);
      check("halt_busy", {31'd0, sif.sc_busy}, 32'd1);
      sif.sc_valid = 1'b1;
      sif.sc_v0    = 32'd9;
      sif.sc_a0    = 32'd4;
      repeat (3) @(posedge clk);
      #1;
      sif.sc_valid = 1'b0;
      check("halt_heap_kept", sif.heap_ptr, BASE);
      check("halt_still", {31'd0, sif.halted}, 32'd1);
      check("halt_exit_kept", {24'd0, sif.exit_code}, 32'hAB);
      @(posedge clk);
      #1;
      check("halt_busy_idle_valid", {31'd0, sif.sc_busy}, 32'd1);

      // exit 10 after reset
      do_reset();
      check("post_reset_halted", {31'd0, sif.halted}, 32'd0);
      issue(32'd10, 32'h55);
      check("exit10_halted", {31'd0, sif.halted}, 32'd1);
      check("exit10_code", {24'd0, sif.exit_code}, 32'd0);

      // async reset while a string waits for memory
      do_reset();
      v0_q.push_back('{BASE, BASE + 32'h4, 1'b0});
      issue(32'd9, 32'd4);
      mem_stall = 1'b1;
      issue(32'd4, 32'h0);
      repeat (4) @(posedge clk);
      #3;
      check("wait_busy", {31'd0, sif.sc_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_heap_ptr", sif.heap_ptr, BASE);
      check("arst_busy", {31'd0, sif.sc_busy}, 32'd0);
      check("arst_mem_req", {31'd0, sif.mem_req}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_stall = 1'b0;
      @(posedge clk);
      #1;

      // sbrk(0) returns current pointer unchanged
      v0_q.push_back('{BASE, BASE, 1'b0});
      issue(32'd9, 32'd0);
      wait_idle(20);
      repeat (2) @(posedge clk);
      #1;
      check("v0_queue_empty", 32'(v0_q.size()), 32'd0);
      check("out_queue_empty", 32'(out_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
